call_request_latch: RTL

//  Consumes debounced, level-type floor-call buttons and latches each press as a pending request.

---
 rtl/call_request_latch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/call_request_latch.sv
// call_request_latch: turns debounced floor-call buttons into latched pending
// requests and scans them for the next target floor (current direction first,
// then the reverse direction from the same start floor).

// Per-floor edge detect and request latch.
module call_request_cell (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic clr_hit,
    output logic press_pulse,
    output logic pending
);
    logic btn_prev;
    logic rise;

    assign rise = btn & ~btn_prev;

    // A button held through reset preloads btn_prev so it never counts as a press;
    // a clear on the same edge as a new press wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev    <= btn;
            press_pulse <= 1'b0;
            pending     <= 1'b0;
        end else begin
            btn_prev    <= btn;
            press_pulse <= rise;
            pending     <= (pending | rise) & ~clr_hit;
        end
    end
endmodule

module call_request_latch #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  btn_db,
    input  logic [FLOOR_W-1:0] cur_floor,
    input  logic               dir_up,
    input  logic               clr_valid,
    input  logic [FLOOR_W-1:0] clr_floor,
    output logic [FLOORS-1:0]  press_pulse,
    output logic [FLOORS-1:0]  pending,
    output logic               target_valid,
    output logic [FLOOR_W-1:0] target_floor
);
    localparam int                 PADW = 1 << FLOOR_W;
    localparam logic [FLOOR_W-1:0] LAST = FLOOR_W'(FLOORS - 1);

    typedef enum logic [1:0] {IDLE, SCAN_FWD, SCAN_REV, HOLD} state_t;

    state_t             state;
    logic [FLOORS-1:0]  clr_hit;
    logic [PADW-1:0]    pend_pad;
    logic [FLOOR_W-1:0] idx;
    logic [FLOOR_W-1:0] start;
    logic               dir;
    logic [FLOOR_W-1:0] start_clamp;
    logic [FLOOR_W-1:0] fwd_end;
    logic [FLOOR_W-1:0] rev_end;
    logic               hit;

    // One cell per floor; out-of-range clr_floor matches no cell.
    for (genvar i = 0; i < FLOORS; i++) begin : g_floor
        assign clr_hit[i] = clr_valid && (clr_floor == FLOOR_W'(i));
        call_request_cell u_cell (
            .clk         (clk),
            .rst         (rst),
            .btn         (btn_db[i]),
            .clr_hit     (clr_hit[i]),
            .press_pulse (press_pulse[i]),
            .pending     (pending[i])
        );
    end

    // Zero-padded copy so idx/target_floor can index any encodable floor safely.
    assign pend_pad    = PADW'(pending);
    assign hit         = pend_pad[idx];
    assign start_clamp = (int'(cur_floor) >= FLOORS) ? LAST : cur_floor;
    assign fwd_end     = dir ? LAST : '0;
    assign rev_end     = dir ? '0 : LAST;

    // Scan FSM: forward from start to the end floor, then reverse from start;
    // HOLD keeps the target until it is served or a new press forces a rescan.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            target_valid <= 1'b0;
            target_floor <= '0;
            idx          <= '0;
            start        <= '0;
            dir          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    target_valid <= 1'b0;
                    if (|pending) begin
                        start <= start_clamp;
                        dir   <= dir_up;
                        idx   <= start_clamp;
                        state <= SCAN_FWD;
                    end
                end
                SCAN_FWD: begin
                    if (hit) begin
                        target_floor <= idx;
                        target_valid <= 1'b1;
                        state        <= HOLD;
                    end else if (idx == fwd_end) begin
                        idx   <= start;
                        state <= SCAN_REV;
                    end else begin
                        idx <= dir ? idx + FLOOR_W'(1) : idx - FLOOR_W'(1);
                    end
                end
                SCAN_REV: begin
                    if (hit) begin
                        target_floor <= idx;
                        target_valid <= 1'b1;
                        state        <= HOLD;
                    end else if (idx == rev_end) begin
                        state <= IDLE;
                    end else begin
                        idx <= dir ? idx - FLOOR_W'(1) : idx + FLOOR_W'(1);
                    end
                end
                HOLD: begin
                    target_valid <= 1'b1;
                    if (!pend_pad[target_floor] || (|press_pulse)) begin
                        target_valid <= 1'b0;
                        start        <= start_clamp;
                        dir          <= dir_up;
                        idx          <= start_clamp;
                        state        <= SCAN_FWD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
